// File: rtl/sensor_ultrassom.sv
// -----------------------------------------------------------------------------
// sensor_ultrassom
// HC-SR04 ultrasonic ranger controller. A free-running period counter fires
// a fixed-width trigger pulse at the start of every measurement period. The
// echo pulse width is then converted to centimetres: one cm for every 58 us
// of echo-high time, saturating at 255.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   echo         : HC-SR04 echo line (asynchronous to clk)
//   trigger      : HC-SR04 trigger pulse, high for TRIG_US at period start
//   distancia_cm : last measured distance in cm (updated only with valido)
//   valido       : one-cycle strobe on the cycle distancia_cm is loaded
//   timeout_err  : level, set by a timed-out measurement, cleared by a good one
// -----------------------------------------------------------------------------
module sensor_ultrassom #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TRIG_US     = 10,
    parameter int PERIOD_MS   = 60,
    parameter int TIMEOUT_MS  = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       echo,
    output logic       trigger,
    output logic [7:0] distancia_cm,
    output logic       valido,
    output logic       timeout_err
);

    localparam int CYC_US      = CLK_FREQ_HZ / 1_000_000;
    localparam int TRIG_CYC    = TRIG_US * CYC_US;
    localparam int CYC_PER_CM  = 58 * CYC_US;
    localparam int PERIOD_CYC  = PERIOD_MS * 1000 * CYC_US;
    localparam int TIMEOUT_CYC = TIMEOUT_MS * 1000 * CYC_US;

    localparam int PER_W = $clog2(PERIOD_CYC);
    localparam int HI_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int SUB_W = $clog2(CYC_PER_CM);

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
    localparam logic [PER_W-1:0] TRIG_END = PER_W'(TRIG_CYC);
    localparam logic [HI_W-1:0]  HI_LIMIT = HI_W'(TIMEOUT_CYC);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYC_PER_CM - 1);

    typedef enum logic [1:0] {
        TRIG      = 2'd0,
        WAIT_ECHO = 2'd1,
        MEDIR     = 2'd2,
        ESPERA    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [PER_W-1:0] per_cnt;
    logic             echo_p0, echo_s, echo_s_d;
    logic [HI_W-1:0]  hi_cnt;
    logic [SUB_W-1:0] sub_cnt;
    logic [7:0]       cm_cnt;

    logic             rise;
    logic [HI_W-1:0]  hi_nxt;
    logic             hi_done;
    logic             hi_run;
    logic             sub_wrap;
    logic [7:0]       cm_nxt;
    logic             meas_done;
    logic             meas_tmo;
    logic             wait_tmo;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---- period counter and trigger --------------------------------------
    // trigger is registered from the pre-increment count, so the first edge
    // after reset release shows count 0 with trigger high, while trigger is
    // still forced low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            trigger <= 1'b0;
        end else begin
            trigger <= (per_cnt < TRIG_END);
            per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
        end
    end

    // ---- echo synchronizer and edge history ------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_p0  <= 1'b0;
            echo_s   <= 1'b0;
            echo_s_d <= 1'b0;
        end else begin
            echo_p0  <= echo;
            echo_s   <= echo_p0;
            echo_s_d <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_s_d;

    // ---- FSM state register ----------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TRIG;
        else        state <= state_nxt;
    end

    // ---- FSM next state --------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            TRIG:      if (per_cnt == TRIG_END) state_nxt = WAIT_ECHO;
            WAIT_ECHO: if (rise)                state_nxt = MEDIR;
                       else if (hi_done)        state_nxt = ESPERA;
            MEDIR:     if (!echo_s || hi_done)  state_nxt = ESPERA;
            ESPERA:    if (per_cnt == '0)       state_nxt = TRIG;
            default:                            state_nxt = TRIG;
        endcase
    end

    // ---- FSM outputs / datapath controls ---------------------------------
    // hi_cnt counts waiting cycles in WAIT_ECHO and echo cycles in MEDIR; it
    // restarts at the rising edge. In MEDIR every cycle is counted, including
    // the one that observes the falling edge, so the rise-to-fall distance
    // equals the number of echo-high cycles.
    always_comb begin
        hi_nxt    = hi_cnt + 1'b1;
        hi_done   = (hi_nxt == HI_LIMIT);
        hi_run    = ((state == WAIT_ECHO) && !rise) || (state == MEDIR);
        sub_wrap  = (sub_cnt == SUB_LAST);
        cm_nxt    = sub_wrap ? sat_inc(cm_cnt) : cm_cnt;
        meas_done = (state == MEDIR) && !echo_s;
        meas_tmo  = (state == MEDIR) && echo_s && hi_done;
        wait_tmo  = (state == WAIT_ECHO) && !rise && hi_done;
    end

    // ---- measurement counters --------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt  <= '0;
            sub_cnt <= '0;
            cm_cnt  <= '0;
        end else begin
            hi_cnt <= hi_run ? hi_nxt : '0;
            if (state == MEDIR) begin
                sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
                cm_cnt  <= cm_nxt;
            end else begin
                sub_cnt <= '0;
                cm_cnt  <= '0;
            end
        end
    end

    // ---- result registers ------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            distancia_cm <= 8'd0;
            valido       <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            valido <= meas_done | meas_tmo;
            if (meas_done) begin
                distancia_cm <= cm_nxt;
                timeout_err  <= 1'b0;
            end else if (meas_tmo) begin
                distancia_cm <= 8'hFF;
                timeout_err  <= 1'b1;
            end else if (wait_tmo) begin
                timeout_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_ultrassom.sv
// -----------------------------------------------------------------------------
// tb_sensor_ultrassom
// Directed bench for sensor_ultrassom at 1 MHz (58 cycles per cm, 10-cycle
// trigger). Period and timeout are shortened to 16 ms / 15 ms so the run stays
// compact; 15 ms still exceeds the 255 cm saturation point (14790 cycles).
// Cycle numbers below count rising edges since the last reset release; the
// edge numbered k is where the period counter reads (k-1) mod 16000.
// -----------------------------------------------------------------------------
module tb_sensor_ultrassom;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       echo = 1'b0;
    logic       trigger;
    logic [7:0] distancia_cm;
    logic       valido;
    logic       timeout_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   vld_cnt = 0;
    int   vld_long = 0;
    logic vld_prev = 1'b0;
    int   snap = 0;
    int   hi_n = 0;
    logic trig_first = 1'b0;

    always #5 clk = ~clk;

    sensor_ultrassom #(
        .CLK_FREQ_HZ(1_000_000),
        .TRIG_US    (10),
        .PERIOD_MS  (16),
        .TIMEOUT_MS (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .echo        (echo),
        .trigger     (trigger),
        .distancia_cm(distancia_cm),
        .valido      (valido),
        .timeout_err (timeout_err)
    );

    // valido pulse bookkeeping, sampled on the falling edge
    always @(negedge clk) begin
        if (valido) begin
            vld_cnt = vld_cnt + 1;
            if (vld_prev) vld_long = vld_long + 1;
        end
        vld_prev = valido;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
        end
    endtask

    task automatic to_cyc(input int t);
        tick(t - cyc);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_trigger", trigger, 0);
        chk("rst_dist", distancia_cm, 0);
        chk("rst_valido", valido, 0);
        chk("rst_err", timeout_err, 0);
        rst_n = 1'b1;
        cyc = 0;

        // trigger after release: high on edges 1..10, low from edge 11
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (cyc == 1) trig_first = trigger;
            hi_n = hi_n + int'(trigger);
        end
        chk("trig_first", trig_first, 1);
        chk("trig_width", hi_n, 10);
        chk("trig_low", trigger, 0);
        chk("idle_dist", distancia_cm, 0);
        chk("idle_valido", valido, 0);
        chk("idle_err", timeout_err, 0);

        // nominal echo: 1160 cycles -> 20 cm, valido 3 cycles after fall
        to_cyc(110);
        echo = 1'b1;
        tick(1160);
        echo = 1'b0;
        tick(2);
        chk("nom_vld_early", valido, 0);
        chk("nom_dist_hold", distancia_cm, 0);
        tick(1);
        chk("nom_valido", valido, 1);
        chk("nom_dist", distancia_cm, 20);
        chk("nom_err", timeout_err, 0);
        tick(1);
        chk("nom_vld_end", valido, 0);
        chk("nom_dist_kept", distancia_cm, 20);

        // period wrap restarts the trigger
        to_cyc(16000);
        chk("p1_trig_low", trigger, 0);
        chk("p1_vld_count", vld_cnt, 1);
        to_cyc(16001);
        chk("wrap_trig", trigger, 1);
        snap = vld_cnt;

        // no echo: timeout 15000 cycles after WAIT_ECHO entry (edge 16011)
        to_cyc(31010);
        chk("noecho_err_early", timeout_err, 0);
        tick(1);
        chk("noecho_err", timeout_err, 1);
        chk("noecho_dist", distancia_cm, 20);
        to_cyc(32000);
        chk("noecho_no_vld", vld_cnt, snap);

        // 57 cycles -> 0 cm; a good echo clears timeout_err
        to_cyc(32111);
        echo = 1'b1;
        tick(57);
        echo = 1'b0;
        tick(3);
        chk("t57_valido", valido, 1);
        chk("t57_dist", distancia_cm, 0);
        chk("t57_err_clr", timeout_err, 0);

        // 115 cycles -> 1 cm
        reset_pulse();
        to_cyc(110);
        echo = 1'b1;
        tick(115);
        echo = 1'b0;
        tick(3);
        chk("t115_valido", valido, 1);
        chk("t115_dist", distancia_cm, 1);

        // 14900 cycles -> saturates at 255 without timing out
        reset_pulse();
        to_cyc(110);
        echo = 1'b1;
        tick(14900);
        echo = 1'b0;
        tick(2);
        chk("sat_vld_early", valido, 0);
        tick(1);
        chk("sat_valido", valido, 1);
        chk("sat_dist", distancia_cm, 255);
        chk("sat_err", timeout_err, 0);

        // echo held 15500 cycles: timeout 15000 cycles after the rise is seen
        reset_pulse();
        to_cyc(110);
        echo = 1'b1;
        tick(15002);
        chk("hold_vld_early", valido, 0);
        chk("hold_err_early", timeout_err, 0);
        tick(1);
        chk("hold_valido", valido, 1);
        chk("hold_dist", distancia_cm, 255);
        chk("hold_err", timeout_err, 1);
        tick(1);
        chk("hold_vld_end", valido, 0);
        tick(496);
        echo = 1'b0;

        // reset 500 cycles into an echo in the following period
        to_cyc(16111);
        snap = vld_cnt;
        echo = 1'b1;
        tick(500);
        rst_n = 1'b0;
        #1;
        chk("arst_trigger", trigger, 0);
        chk("arst_dist", distancia_cm, 0);
        chk("arst_valido", valido, 0);
        chk("arst_err", timeout_err, 0);
        echo = 1'b0;
        tick(3);
        rst_n = 1'b1;
        cyc = 0;
        tick(1);
        chk("arst_trig_restart", trigger, 1);
        chk("arst_no_vld", vld_cnt, snap);
        chk("vld_single_cycle", vld_long, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_ultrassom.md
SENSOR_ULTRASSOM -- requirements
Module: sensor_ultrassom

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, clock frequency in Hz; must be a multiple of 1_000_000.
REQ-002 SHALL have parameter TRIG_US, default 10, trigger pulse width in microseconds.
REQ-003 SHALL have parameter PERIOD_MS, default 60, measurement period in milliseconds.
REQ-004 SHALL have parameter TIMEOUT_MS, default 30, echo wait and echo high limit in milliseconds; must be less than PERIOD_MS.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port echo  input  1  HC-SR04 echo line, asynchronous to clk.
REQ-008 SHALL have port trigger  output  1  HC-SR04 trigger pulse.
REQ-009 SHALL have port distancia_cm  output  8  last measured distance in cm; feeds the downstream LED/limit stage directly.
REQ-010 SHALL have port valido  output  1  one-cycle pulse on the cycle distancia_cm is updated.
REQ-011 SHALL have port timeout_err  output  1  level, high after a timed-out measurement.

Function
REQ-012 SHALL use these derived constants: CYC_US = CLK_FREQ_HZ/1_000_000, TRIG_CYC = TRIG_US*CYC_US, CYC_PER_CM = 58*CYC_US, PERIOD_CYC = PERIOD_MS*1000*CYC_US, TIMEOUT_CYC = TIMEOUT_MS*1000*CYC_US.
REQ-013 SHALL pass echo through a 2-flop synchronizer; all echo edge detection uses the synchronized signal (echo_s).
REQ-014 SHALL run a free-running period counter 0..PERIOD_CYC-1 that wraps to 0; trigger is 1 exactly when the count < TRIG_CYC, independent of FSM state.
REQ-015 SHALL implement the FSM states TRIG, WAIT_ECHO, MEDIR and ESPERA.
REQ-016 SHALL transition TRIG->WAIT_ECHO when the period count reaches TRIG_CYC.
REQ-017 SHALL transition WAIT_ECHO->MEDIR on an echo_s rising edge, clearing the echo-cycle counter and the cm counter.
REQ-018 SHALL, if WAIT_ECHO persists for TIMEOUT_CYC cycles, set timeout_err=1, leave distancia_cm unchanged, pulse no valido, and go to ESPERA.
REQ-019 SHALL, in MEDIR, increment the cm counter once per CYC_PER_CM completed echo-high cycles, saturating at 255; the result is floor(high_cycles/CYC_PER_CM) clamped to 255.
REQ-020 SHALL, on an echo_s falling edge in MEDIR, load distancia_cm with the cm count, assert valido for that same cycle, clear timeout_err, and go to ESPERA.
REQ-021 SHALL, if echo_s stays high for TIMEOUT_CYC cycles in MEDIR, load distancia_cm=255, assert valido, set timeout_err=1, and go to ESPERA.
REQ-022 SHALL transition ESPERA->TRIG when the period counter wraps to 0, ignoring echo.
REQ-023 SHALL treat an echo_s already high on entry to WAIT_ECHO as having no rising edge, which ends in the REQ-018 timeout.
REQ-024 SHALL limit distancia_cm to at most one update per period; valido never lasts longer than 1 cycle.
REQ-025 SHALL make distancia_cm change only on cycles where valido=1.

Reset
REQ-026 SHALL, while rst_n=0, immediately force: trigger=0, distancia_cm=0, valido=0, timeout_err=0, FSM=TRIG, period counter=0, synchronizer flops=0.
REQ-027 SHALL, on the first rising clk edge after rst_n deasserts, begin period count 0 with trigger=1.
REQ-028 SHALL, when reset is asserted mid-measurement, abort the measurement with no valido pulse; the next trigger starts a fresh period.

Verification
(All scenarios use CLK_FREQ_HZ=1_000_000, so CYC_PER_CM=58, TRIG_CYC=10, PERIOD_CYC=60000, TIMEOUT_CYC=30000.)
REQ-029 SHALL cover reset release: trigger high for exactly 10 cycles then low; distancia_cm=0, valido=0 and timeout_err=0 until echo activity.
REQ-030 SHALL cover a nominal echo: 100 us after trigger falls, echo high for 1160 cycles -> distancia_cm=20, one valido pulse 3 cycles after echo falls, timeout_err=0.
REQ-031 SHALL cover truncation: echo high for 57 cycles -> distancia_cm=0; echo high for 115 cycles -> distancia_cm=1.
REQ-032 SHALL cover saturation and timeout: echo high for 20000 cycles -> distancia_cm=255, timeout_err=0; echo held high 40000 cycles -> distancia_cm=255, valido pulse, timeout_err=1.
REQ-033 SHALL cover no echo: echo never rises -> timeout_err=1 about 30000 cycles after trigger falls, distancia_cm keeps its prior value (20), no valido; the next good echo clears timeout_err.
REQ-034 SHALL cover reset mid-echo: assert rst_n=0 500 cycles into echo high -> outputs go to 0 asynchronously, no valido; after release, trigger is high at cycle 0 of a new period.
